// File: rtl/operand_bank_pkg.sv
// operand_bank_pkg: shared bank state type and project default sizes
package operand_bank_pkg;
  localparam int DW_DEF = 4;
  localparam int DEPTH_DEF = 2;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_e;
endpackage

// File: rtl/operand_bank_if.sv
// operand_bank_if: load/flush/consume controls and bank status between front-end and bank
interface operand_bank_if
  import operand_bank_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
);
  localparam int CW = $clog2(DEPTH + 1);
  logic load;
  logic clear;
  logic consume;
  logic [DW-1:0] in;
  logic [DEPTH*DW-1:0] operands;
  logic [CW-1:0] count;
  logic loaded;
  logic empty;
  logic ovf;
  modport master(output load, clear, consume, in, input operands, count, loaded, empty, ovf);
  modport slave(input load, clear, consume, in, output operands, count, loaded, empty, ovf);
endinterface

// File: rtl/operand_slot.sv
// operand_slot: one operand register with write enable and synchronous clear
module operand_slot #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  logic [DW-1:0] q_q, q_d;
  // clear beats write; otherwise the slot holds its value
  always_comb q_d = clr ? '0 : we ? d : q_q;
  // slot register, active-low synchronous reset
  always_ff @(posedge clk) begin
    if (!rst) q_q <= '0;
    else q_q <= q_d;
  end
  assign q = q_q;
endmodule

// File: rtl/operand_bank.sv
// operand_bank: fills DEPTH ordered operand slots, holds the full set until consumed
module operand_bank
  import operand_bank_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic clk,
  input logic rst,
  operand_bank_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  bank_state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d, wr_idx;
  logic ovf_q, ovf_d, wr_en, slot_clr;
  logic [DEPTH-1:0] we;
  // priority clear > consume > load; state follows the resulting count
  always_comb begin
    count_d = count_q;
    ovf_d = ovf_q;
    wr_en = 1'b0;
    wr_idx = count_q;
    slot_clr = 1'b0;
    if (bus.clear) begin
      count_d = '0;
      ovf_d = 1'b0;
      slot_clr = 1'b1;
    end else if (state_q == FULL && bus.consume) begin
      wr_en = bus.load;
      wr_idx = '0;
      count_d = bus.load ? CW'(1) : '0;
    end else if (bus.load) begin
      if (state_q == FULL) ovf_d = 1'b1;
      else begin
        wr_en = 1'b1;
        count_d = count_q + CW'(1);
      end
    end
    state_d = count_d == '0 ? EMPTY : count_d == CW'(DEPTH) ? FULL : FILLING;
  end
  // state, count and sticky overflow registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
    end
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign we[i] = wr_en && wr_idx == CW'(i);
    operand_slot #(.DW(DW)) u_slot (
      .clk(clk),
      .rst(rst),
      .clr(slot_clr),
      .we(we[i]),
      .d(bus.in),
      .q(bus.operands[i*DW +: DW])
    );
  end
  assign bus.count = count_q;
  assign bus.loaded = state_q == FULL;
  assign bus.empty = state_q == EMPTY;
  assign bus.ovf = ovf_q;
endmodule

// File: doc/operand_bank.md
# operand_bank

Parametrised multi-slot successor to the single-operand load register. Captures a stream of DW-bit operands, one per `load` pulse, into DEPTH ordered slots; flags when the set is complete; holds it stable until the consumer (ALU/sequencer) acknowledges with `consume`. Sits between the input front-end (switches/UART decoder) and the arithmetic core; flags load overflow instead of silently dropping data.

## Interface
- DW, 4, operand width in bits (≥1)
- DEPTH, 2, number of operand slots (≥1)
- CW, $clog2(DEPTH+1), count width (derived, not overridden)

- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset
- load  in  1  capture `in` into the next free slot this cycle
- in  in  DW  operand data
- clear  in  1  synchronous flush of bank and flags
- consume  in  1  consumer acknowledges full set; bank releases
- operands  out  DEPTH*DW  slot i at [i*DW +: DW], slot 0 = first loaded
- count  out  CW  number of valid slots (0..DEPTH)
- loaded  out  1  high while all DEPTH slots valid (state FULL)
- empty  out  1  high while count == 0
- ovf  out  1  sticky: a load arrived while FULL without consume

## Operation
- FSM states: EMPTY, FILLING, FULL.
- Priority per edge: rst low > clear > consume > load.
- rst low or clear: all slots 0, count 0, state EMPTY, ovf 0; load/consume that cycle ignored.
- EMPTY + load: slot[0] ← in, count 1; next state FILLING (FULL if DEPTH==1).
- FILLING + load: slot[count] ← in, count+1; FULL when count reaches DEPTH.
- FULL + load, no consume: data discarded, slots/count unchanged, ovf ← 1.
- FULL + consume, no load: count 0, state EMPTY; slot contents retained (not zeroed) until overwritten.
- FULL + consume + load: release and restart in one edge: slot[0] ← in, count 1, state FILLING (FULL if DEPTH==1); ovf unchanged.
- consume outside FULL: ignored, no flag.
- No load: all slots hold value.
- ovf clears only on rst or clear.
- count never exceeds DEPTH; write index never wraps past DEPTH-1.

## Timing
- All outputs registered; effect of an edge visible in the following cycle.
- Load latency: 1 cycle from `load` sample to data on `operands` and updated `count`.
- `loaded` rises the cycle after the DEPTH-th load; falls the cycle after `consume`.
- Back-to-back loads every cycle accepted at full rate.
- Reset values: operands 0, count 0, loaded 0, empty 1, ovf 0.
- Reset or clear mid-fill discards partial set; next load goes to slot 0.

## Structure
- Pkg_Global: bank state enum typedef (EMPTY/FILLING/FULL) and DW/DEPTH project defaults.
- Sub-module `operand_slot`: one DW-bit register with write-enable and synchronous clear, instantiated DEPTH times via generate; top holds FSM, count, write-index decode, ovf.

## Test plan (DW=4, DEPTH=3)
- Reset: rst low 2 cycles with load=1, in=4'hF → operands 0, count 0, empty 1, loaded 0, ovf 0.
- Fill: loads 4'h1, 4'h2, 4'h3 on consecutive cycles → operands 12'h321, count 3, loaded 1 one cycle after 3rd load.
- Overflow: in FULL, load 4'h9 → operands stay 12'h321, ovf 1 and stays 1 after consume; clear → ovf 0, operands 0.
- Consume+load: FULL with 12'h321, consume=1 and load=1 with 4'hA → count 1, slot 0 = A, loaded 0, state FILLING.
- Clear mid-fill: load 4'h5, 4'h6, then clear together with load 4'h7 → count 0, empty 1, operands 0; next load 4'h8 lands in slot 0.
- DEPTH=1 variant: load 4'hC → loaded 1 next cycle; consume+load 4'hD → loaded stays 1, operands 4'hD.
